// File: rtl/intgen_multi.sv
// Multi-channel countdown interrupt generator with a Wishbone register interface.
// Define INTGEN_MULTI_SWTRIG_EN to make 0x0C a write-1-to-set software trigger on PENDING.
module intgen_multi #(
  parameter int unsigned NUM_IRQ   = 4,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic [7:0]         wb_adr_i,
  input  logic [31:0]        wb_dat_i,
  input  logic               wb_we_i,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  output logic [31:0]        wb_dat_o,
  output logic               wb_ack_o,
  output logic [NUM_IRQ-1:0] irq_o
);

  localparam int unsigned REG_COUNT0 = 4;

  logic                 access;
  logic                 wr;
  logic [5:0]           reg_idx;
  logic [NUM_IRQ-1:0]   pending;
  logic [NUM_IRQ-1:0]   mask;
  logic [NUM_IRQ-1:0]   reload_en;
  logic [NUM_IRQ-1:0]   expire;
  logic [NUM_IRQ-1:0]   count_wr;
  logic [NUM_IRQ-1:0]   clr_bits;
  logic [NUM_IRQ-1:0]   set_bits;
  logic [CNT_WIDTH-1:0] cnt [NUM_IRQ];
  logic [CNT_WIDTH-1:0] rld [NUM_IRQ];
  logic [31:0]          rd_data;
  logic                 unused_bits;

  // Access happens on the edge that raises ack, so each transfer has one wait state.
  assign access  = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr      = access & wb_we_i;
  assign reg_idx = wb_adr_i[7:2];

  assign unused_bits = ^{wb_adr_i[1:0], wb_dat_i};

  always_comb begin
    count_wr = '0;
    expire   = '0;
    for (int unsigned n = 0; n < NUM_IRQ; n++) begin
      count_wr[n] = wr && (reg_idx == 6'(REG_COUNT0 + n));
      // A COUNT write in the same cycle overrides the expiry.
      expire[n]   = (cnt[n] == CNT_WIDTH'(1)) && !count_wr[n];
    end
  end

  assign clr_bits = (wr && reg_idx == 6'd0) ? wb_dat_i[NUM_IRQ-1:0] : '0;

`ifdef INTGEN_MULTI_SWTRIG_EN
  assign set_bits = (wr && reg_idx == 6'd3) ? wb_dat_i[NUM_IRQ-1:0] : '0;
`else
  assign set_bits = '0;
`endif

  always_comb begin
    rd_data = '0;
    case (reg_idx)
      6'd0:    rd_data = 32'(pending);
      6'd1:    rd_data = 32'(mask);
      6'd2:    rd_data = 32'(reload_en);
      default: begin
        for (int unsigned n = 0; n < NUM_IRQ; n++) begin
          if (reg_idx == 6'(REG_COUNT0 + n)) rd_data = 32'(cnt[n]);
        end
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wb_ack_o  <= 1'b0;
      wb_dat_o  <= '0;
      pending   <= '0;
      mask      <= '0;
      reload_en <= '0;
      for (int unsigned n = 0; n < NUM_IRQ; n++) begin
        cnt[n] <= '0;
        rld[n] <= '0;
      end
    end else begin
      wb_ack_o <= access;
      wb_dat_o <= access ? rd_data : '0;
      if (wr && reg_idx == 6'd1) mask      <= wb_dat_i[NUM_IRQ-1:0];
      if (wr && reg_idx == 6'd2) reload_en <= wb_dat_i[NUM_IRQ-1:0];
      // Set sources win over the write-1-to-clear.
      pending <= (pending & ~clr_bits) | expire | set_bits;
      for (int unsigned n = 0; n < NUM_IRQ; n++) begin
        if (count_wr[n]) begin
          cnt[n] <= wb_dat_i[CNT_WIDTH-1:0];
          rld[n] <= wb_dat_i[CNT_WIDTH-1:0];
        end else if (expire[n]) begin
          cnt[n] <= reload_en[n] ? rld[n] : '0;
        end else if (cnt[n] != '0) begin
          cnt[n] <= cnt[n] - CNT_WIDTH'(1);
        end
      end
    end
  end

  assign irq_o = pending & mask;

endmodule

// File: tb/tb_intgen_multi.sv
// Scoreboard bench for intgen_multi: an expiry-time reference model predicts
// read data, ack and irq_o; a monitor compares on every falling edge.
module tb_intgen_multi;
  localparam int NUM_IRQ   = 4;
  localparam int CNT_WIDTH = 16;
  localparam int CMASK     = (1 << CNT_WIDTH) - 1;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [7:0]         adr = '0;
  logic [31:0]        dat_i = '0;
  logic               we = 1'b0;
  logic               cyc = 1'b0;
  logic               stb = 1'b0;
  logic [31:0]        dat_o;
  logic               ack;
  logic [NUM_IRQ-1:0] irq;

  always #5 clk = ~clk;

  intgen_multi #(.NUM_IRQ(NUM_IRQ), .CNT_WIDTH(CNT_WIDTH)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_i),
    .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_dat_o(dat_o),
    .wb_ack_o(ack), .irq_o(irq)
  );

  typedef struct packed { logic rd; logic [31:0] d; } exp_t;
  exp_t sbq[$];

  int total = 0;
  int bad   = 0;

  // Reference model: each channel is described by the absolute edge of its next
  // expiry (0 = idle) and its reload period, not by a ticking counter.
  int                 t = 0;
  bit [NUM_IRQ-1:0]   m_pend = '0;
  bit [NUM_IRQ-1:0]   m_mask = '0;
  bit [NUM_IRQ-1:0]   m_rlen = '0;
  bit                 m_ack = 1'b0;
  int                 next_exp [NUM_IRQ];
  int                 period   [NUM_IRQ];

  initial foreach (next_exp[n]) begin next_exp[n] = 0; period[n] = 0; end

  function automatic logic [31:0] m_read(int idx);
    if (idx == 0) return 32'(m_pend);
    if (idx == 1) return 32'(m_mask);
    if (idx == 2) return 32'(m_rlen);
    if (idx >= 4 && idx < 4 + NUM_IRQ)
      return (next_exp[idx-4] != 0) ? 32'(next_exp[idx-4] - t + 1) : 32'd0;
    return 32'd0;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    bit               acc;
    int               idx;
    int               v;
    bit [NUM_IRQ-1:0] expd;
    bit [NUM_IRQ-1:0] clr;
    bit [NUM_IRQ-1:0] sw;
    t++;
    if (rst) begin
      m_pend = '0; m_mask = '0; m_rlen = '0; m_ack = 1'b0;
      foreach (next_exp[n]) begin next_exp[n] = 0; period[n] = 0; end
      sbq.delete();
    end else begin
      acc  = cyc && stb && !m_ack;
      idx  = int'(adr[7:2]);
      expd = '0; clr = '0; sw = '0;
      for (int n = 0; n < NUM_IRQ; n++)
        expd[n] = (next_exp[n] == t) && !(acc && we && idx == 4 + n);
      if (acc) sbq.push_back('{rd: !we, d: we ? 32'd0 : m_read(idx)});
      for (int n = 0; n < NUM_IRQ; n++)
        if (expd[n]) next_exp[n] = (m_rlen[n] && period[n] != 0) ? t + period[n] : 0;
      if (acc && we) begin
        if (idx == 0) clr = dat_i[NUM_IRQ-1:0];
        if (idx == 1) m_mask = dat_i[NUM_IRQ-1:0];
        if (idx == 2) m_rlen = dat_i[NUM_IRQ-1:0];
`ifdef INTGEN_MULTI_SWTRIG_EN
        if (idx == 3) sw = dat_i[NUM_IRQ-1:0];
`endif
        if (idx >= 4 && idx < 4 + NUM_IRQ) begin
          v = int'(dat_i) & CMASK;
          period[idx-4]   = v;
          next_exp[idx-4] = (v != 0) ? t + v : 0;
        end
      end
      m_pend = (m_pend & ~clr) | expd | sw;
      m_ack  = acc;
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    check("ack", 32'(ack), 32'(m_ack));
    check("irq", 32'(irq), 32'(m_pend & m_mask));
    if (ack === 1'b1) begin
      if (sbq.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_underflow: got unexpected ack, required none at %0t", $time);
      end else begin
        e = sbq.pop_front();
        if (e.rd) check("rdata", dat_o, e.d);
      end
    end
  end

  // Called at a falling edge; the access lands on the next rising edge.
  task automatic xfer(bit w, int idx, logic [31:0] d);
    if (m_ack) @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = {6'(idx), 2'($urandom_range(0, 3))}; dat_i = d;
    @(posedge clk);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic idle(int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic read_all();
    for (int i = 0; i < 10; i++) xfer(1'b0, i, '0);
    xfer(1'b0, 63, '0);
  endtask

  initial begin : stim
    int idx;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    read_all();

    // one-shot channel 0
    xfer(1'b1, 1, 32'h1);
    xfer(1'b1, 4, 32'd5);
    idle(8);
    xfer(1'b0, 4, '0);
    xfer(1'b0, 0, '0);
    xfer(1'b1, 0, 32'h1);
    idle(2);

    // periodic channel 1
    xfer(1'b1, 2, 32'h2);
    xfer(1'b1, 1, 32'h2);
    xfer(1'b1, 5, 32'd3);
    idle(10);
    xfer(1'b1, 0, 32'h2);
    idle(1);
    xfer(1'b0, 0, '0);
    idle(6);
    xfer(1'b1, 5, 32'd0);
    xfer(1'b1, 0, 32'h2);
    idle(10);
    xfer(1'b0, 0, '0);
    xfer(1'b0, 5, '0);

    // masked channel 2
    xfer(1'b1, 1, 32'h0);
    xfer(1'b1, 6, 32'd4);
    idle(6);
    xfer(1'b0, 0, '0);
    xfer(1'b1, 1, 32'h4);
    idle(2);
    xfer(1'b1, 0, 32'hF);

    // W1C on the expiry edge, then COUNT rewrite on the expiry edge
    xfer(1'b1, 1, 32'h1);
    xfer(1'b1, 4, 32'd1);
    idle(3);
    xfer(1'b1, 4, 32'd5);
    idle(4);
    xfer(1'b1, 0, 32'h1);
    xfer(1'b0, 0, '0);
    xfer(1'b1, 0, 32'h1);
    xfer(1'b1, 4, 32'd6);
    idle(5);
    xfer(1'b1, 4, 32'd10);
    xfer(1'b0, 0, '0);
    idle(12);
    xfer(1'b0, 0, '0);

    // software trigger register
    xfer(1'b1, 3, 32'h9);
    xfer(1'b1, 1, 32'hF);
    xfer(1'b0, 0, '0);
    xfer(1'b0, 3, '0);
    idle(2);

    // reset mid-count
    xfer(1'b1, 2, 32'hF);
    xfer(1'b1, 7, 32'd2);
    idle(3);
    do_reset();
    read_all();

    for (int i = 0; i < 300; i++) begin
      idx = ($urandom_range(0, 15) == 0) ? 63 : int'($urandom_range(0, 9));
      if ($urandom_range(0, 2) == 0)
        xfer(1'b0, idx, '0);
      else if (idx >= 4 && idx < 8)
        xfer(1'b1, idx, 32'($urandom_range(0, 9)) | (32'($urandom_range(0, 1)) << 20));
      else
        xfer(1'b1, idx, $urandom);
      idle(int'($urandom_range(0, 3)));
      if ($urandom_range(0, 59) == 0) do_reset();
    end

    idle(4);
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d outstanding, required 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
